// File: rtl/col2im.sv
// col2im: scatter-adds a 3x3 column buffer back into an image
// and writes the saturated reconstruction to memory.
module col2im #(
  parameter int          IMG_W       = 8,
  parameter int          IMG_H       = 8,
  parameter int          DATA_WIDTH  = 8,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          ACC_WIDTH   = 12,
  parameter logic [15:0] IM2COL_BASE = 16'h2000,
  parameter logic [15:0] OUT_BASE    = 16'h4000
) (
  input  logic                  clk,
  input  logic                  rst_im2col,
  input  logic [DATA_WIDTH-1:0] data_rd,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [DATA_WIDTH-1:0] data_wr,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic                  mem_wr_en,
  output logic                  col2im_done
);

  localparam int IMG_NUM = IMG_W * IMG_H;
  localparam int COL_NUM = IMG_NUM * 9;
  localparam int RCW = $clog2(COL_NUM);
  localparam int WCW = $clog2(IMG_NUM + 1);
  localparam int PW  = (IMG_NUM > 1) ? $clog2(IMG_NUM) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [1:0] S_RD   = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((2 ** DATA_WIDTH) - 1);

  logic [1:0]           state;
  logic [RCW-1:0]       rd_cnt;
  logic [3:0]           tap;
  logic [RW-1:0]        row;
  logic [CW-1:0]        col;
  logic [WCW-1:0]       wr_cnt;
  logic [ACC_WIDTH-1:0] acc [IMG_NUM];

  logic [1:0]           kr;
  logic [1:0]           kc;
  int                   tr;
  int                   tc;
  logic                 hit;
  logic [PW-1:0]        tidx;
  logic [ACC_WIDTH-1:0] acc_w;
  logic [DATA_WIDTH-1:0] sat_val;

  assign addr_rd = ADDR_WIDTH'(IM2COL_BASE) + ADDR_WIDTH'(rd_cnt);

  // Decode the tap into a 3x3 offset and locate the target pixel.
  always_comb begin
    kr = 2'd0;
    kc = 2'd0;
    unique case (tap)
      4'd0: begin kr = 2'd0; kc = 2'd0; end
      4'd1: begin kr = 2'd0; kc = 2'd1; end
      4'd2: begin kr = 2'd0; kc = 2'd2; end
      4'd3: begin kr = 2'd1; kc = 2'd0; end
      4'd4: begin kr = 2'd1; kc = 2'd1; end
      4'd5: begin kr = 2'd1; kc = 2'd2; end
      4'd6: begin kr = 2'd2; kc = 2'd0; end
      4'd7: begin kr = 2'd2; kc = 2'd1; end
      4'd8: begin kr = 2'd2; kc = 2'd2; end
      default: begin kr = 2'd0; kc = 2'd0; end
    endcase
    tr   = int'(row) + int'(kr) - 1;
    tc   = int'(col) + int'(kc) - 1;
    hit  = (tr >= 0) && (tr < IMG_H) && (tc >= 0) && (tc < IMG_W);
    tidx = PW'(tr * IMG_W + tc);
  end

  // Saturate the accumulator being written out.
  always_comb begin
    acc_w   = acc[wr_cnt[PW-1:0]];
    sat_val = (acc_w > SAT_MAX) ? '1 : acc_w[DATA_WIDTH-1:0];
  end

  // Sequencer: walk the column buffer, then stream out the image.
  always_ff @(posedge clk or posedge rst_im2col) begin
    if (rst_im2col) begin
      state       <= S_RD;
      rd_cnt      <= '0;
      tap         <= '0;
      row         <= '0;
      col         <= '0;
      wr_cnt      <= '0;
      mem_wr_en   <= 1'b0;
      data_wr     <= '0;
      addr_wr     <= ADDR_WIDTH'(OUT_BASE);
      col2im_done <= 1'b0;
    end else begin
      unique case (state)
        S_RD: begin
          if (rd_cnt == RCW'(COL_NUM - 1)) state <= S_WR;
          else rd_cnt <= rd_cnt + 1'b1;
          if (tap == 4'd8) begin
            tap <= '0;
            if (col == CW'(IMG_W - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end else begin
            tap <= tap + 1'b1;
          end
        end
        S_WR: begin
          if (wr_cnt == WCW'(IMG_NUM)) begin
            mem_wr_en   <= 1'b0;
            col2im_done <= 1'b1;
            state       <= S_DONE;
          end else begin
            mem_wr_en <= 1'b1;
            addr_wr   <= ADDR_WIDTH'(OUT_BASE) + ADDR_WIDTH'(wr_cnt);
            data_wr   <= sat_val;
            wr_cnt    <= wr_cnt + 1'b1;
          end
        end
        default: begin
          mem_wr_en <= 1'b0;
        end
      endcase
    end
  end

  // Scatter-add non-padding entries into their image pixel.
  always_ff @(posedge clk or posedge rst_im2col) begin
    if (rst_im2col) begin
      for (int i = 0; i < IMG_NUM; i++) acc[i] <= '0;
    end else if (state == S_RD && hit) begin
      acc[tidx] <= acc[tidx] + ACC_WIDTH'(data_rd);
    end
  end

endmodule

// File: tb/tb_col2im.sv
// tb_col2im: random and directed checks of col2im against a
// gather-form reference model, on a 4x4 and a default 8x8 instance.
module tb_col2im;

  logic        clk = 1'b0;
  logic        rst4 = 1'b1;
  logic        rst8 = 1'b1;
  logic [7:0]  d_rd4, d_wr4, d_rd8, d_wr8;
  logic [31:0] a_rd4, a_wr4, a_rd8, a_wr8;
  logic        we4, done4, we8, done8;

  logic [7:0]  colbuf [576];
  logic [7:0]  img [64];
  int          expv [64];
  int          got [64];
  int          hits [64];
  int          W = 4;
  int          H = 4;
  int          sel = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] ard, awr;
  logic [7:0]  dwr;
  logic        we, done;

  always #5 clk = ~clk;

  col2im #(.IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .rst_im2col(rst4), .data_rd(d_rd4), .addr_rd(a_rd4),
    .data_wr(d_wr4), .addr_wr(a_wr4), .mem_wr_en(we4),
    .col2im_done(done4)
  );

  col2im u_dut8 (
    .clk(clk), .rst_im2col(rst8), .data_rd(d_rd8), .addr_rd(a_rd8),
    .data_wr(d_wr8), .addr_wr(a_wr8), .mem_wr_en(we8),
    .col2im_done(done8)
  );

  assign d_rd4 = (a_rd4 >= 32'h2000 && a_rd4 < 32'h2000 + 144) ?
                 colbuf[a_rd4 - 32'h2000] : 8'h00;
  assign d_rd8 = (a_rd8 >= 32'h2000 && a_rd8 < 32'h2000 + 576) ?
                 colbuf[a_rd8 - 32'h2000] : 8'h00;

  // View of whichever instance is under test.
  always_comb begin
    ard  = (sel != 0) ? a_rd8 : a_rd4;
    awr  = (sel != 0) ? a_wr8 : a_wr4;
    dwr  = (sel != 0) ? d_wr8 : d_wr4;
    we   = (sel != 0) ? we8 : we4;
    done = (sel != 0) ? done8 : done4;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, obs, obs, exp, exp);
    end
  endtask

  task automatic set_size(input int s);
    sel = s;
    W = (s != 0) ? 8 : 4;
    H = W;
  endtask

  task automatic set_rst(input logic v);
    if (sel != 0) rst8 = v;
    else rst4 = v;
  endtask

  function automatic void clear_buf();
    for (int i = 0; i < 576; i++) colbuf[i] = 8'h00;
  endfunction

  // Column-expand img; out-of-image taps get the pad value.
  function automatic void build_im2col(input int pad);
    int r, c, tr, tc;
    for (int p = 0; p < W * H; p++) begin
      r = p / W;
      c = p % W;
      for (int k = 0; k < 9; k++) begin
        tr = r + k / 3 - 1;
        tc = c + k % 3 - 1;
        if (tr >= 0 && tr < H && tc >= 0 && tc < W)
          colbuf[p * 9 + k] = img[tr * W + tc];
        else
          colbuf[p * 9 + k] = pad[7:0];
      end
    end
  endfunction

  // Gather view: pixel (r,c) collects, from each neighbouring
  // centre, the tap that points back at it.
  function automatic void model();
    int s, cr, cc, k;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        s = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            cr = r - dr;
            cc = c - dc;
            k  = (dr + 1) * 3 + (dc + 1);
            if (cr >= 0 && cr < H && cc >= 0 && cc < W)
              s += int'(colbuf[(cr * W + cc) * 9 + k]);
          end
        end
        expv[r * W + c] = (s > 255) ? 255 : s;
      end
    end
  endfunction

  task automatic chk_rst(input string p);
    chk({p, "_we"}, {31'd0, we}, 32'd0);
    chk({p, "_done"}, {31'd0, done}, 32'd0);
    chk({p, "_addr_wr"}, awr, 32'h4000);
    chk({p, "_data_wr"}, {24'd0, dwr}, 32'd0);
    chk({p, "_addr_rd"}, ard, 32'h2000);
  endtask

  task automatic run(input string tag, input int abort_at);
    int np, nc, nwr, first_wr, done_edge, addr_err;
    int bad_addr, dup, drop, idx;
    logic [31:0] ea;
    np = W * H;
    nc = np * 9;
    nwr = 0; first_wr = -1; done_edge = -1;
    addr_err = 0; bad_addr = 0; dup = 0; drop = 0;
    for (int i = 0; i < 64; i++) begin
      got[i]  = -1;
      hits[i] = 0;
    end
    @(negedge clk);
    set_rst(1'b1);
    #1;
    chk_rst({tag, "_rst"});
    @(negedge clk);
    set_rst(1'b0);
    for (int n = 1; n <= nc + np + 8; n++) begin
      @(posedge clk);
      #1;
      ea = 32'h2000 + 32'((n < nc) ? n : nc - 1);
      if (ard !== ea) addr_err++;
      if (we === 1'b1) begin
        nwr++;
        if (first_wr < 0) first_wr = n;
        idx = int'(awr) - 32'h4000;
        if (idx >= 0 && idx < np) begin
          got[idx] = int'(dwr);
          hits[idx]++;
        end else begin
          bad_addr++;
        end
      end
      if (done === 1'b1 && done_edge < 0) done_edge = n;
      if (done !== 1'b1 && done_edge >= 0) drop++;
      if (n == abort_at) begin
        #2;
        set_rst(1'b1);
        #1;
        chk_rst({tag, "_abort"});
        return;
      end
    end
    chk({tag, "_done_edge"}, done_edge, nc + np + 1);
    chk({tag, "_first_wr_edge"}, first_wr, nc + 1);
    chk({tag, "_wr_count"}, nwr, np);
    chk({tag, "_addr_rd_err"}, addr_err, 0);
    chk({tag, "_bad_wr_addr"}, bad_addr, 0);
    chk({tag, "_done_drop"}, drop, 0);
    for (int i = 0; i < np; i++) if (hits[i] != 1) dup++;
    chk({tag, "_addr_cover"}, dup, 0);
    for (int i = 0; i < np; i++)
      chk($sformatf("%s_pix%0d", tag, i), got[i], expv[i]);
  endtask

  task automatic fill_img(input int v);
    for (int i = 0; i < 64; i++) img[i] = v[7:0];
  endtask

  initial begin
    set_size(0);

    fill_img(1); build_im2col(0); model();
    run("ones", 0);
    chk("ones_corner", got[0], 4);
    chk("ones_edge", got[1], 6);
    chk("ones_inner", got[5], 9);

    fill_img(28); build_im2col(0); model();
    run("v28", 0);
    chk("v28_corner", got[15], 112);
    chk("v28_edge", got[4], 168);
    chk("v28_inner", got[10], 252);

    fill_img(64); build_im2col(0); model();
    run("v64", 0);
    chk("v64_corner", got[0], 255);
    chk("v64_inner", got[5], 255);

    fill_img(0); build_im2col(255); model();
    run("pad", 0);
    chk("pad_corner", got[0], 0);
    chk("pad_edge", got[2], 0);

    clear_buf();
    colbuf[4] = 8'd5;
    colbuf[45] = 8'd7;
    model();
    run("single_a", 0);
    chk("single_a_out0", got[0], 12);
    chk("single_a_out5", got[5], 0);

    clear_buf();
    colbuf[8] = 8'd3;
    model();
    run("single_b", 0);
    chk("single_b_out5", got[5], 3);
    chk("single_b_out0", got[0], 0);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 255));
      build_im2col(0); model();
      run($sformatf("rimg%0d", t), 0);
    end
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 576; i++)
        colbuf[i] = 8'($urandom_range(0, (t == 2) ? 255 : 40));
      model();
      run($sformatf("rbuf%0d", t), 0);
    end
    rst4 = 1'b1;

    set_size(1);
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom_range(0, 40));
    build_im2col(0); model();
    run("d8", 0);
    run("d8_ab_rd", 100);
    run("d8_after_rd", 0);
    for (int i = 0; i < 576; i++) colbuf[i] = 8'($urandom_range(0, 60));
    model();
    run("d8_ab_wr", 600);
    run("d8_after_wr", 0);
    rst8 = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
